// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer
// ------------------
// Drives the two-flip-flop lab FSM one step at a time. A start command
// latches a serial pattern of x values. Each bit is then applied by holding
// E high for exactly one clock. After that step, {Qa,Qb} is captured into a
// trace slot. When the sequence finishes, done pulses for one cycle.
//
// Command handshake: start is looked at only while the block is idle (busy
// low). The edge that samples start high accepts the command. busy goes high
// in the next cycle and stays high through the done cycle. done is a
// one-cycle pulse. A start that arrives while busy is dropped, not queued.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset; aborts any sequence in flight
//   start     command request, sampled only while idle
//   pattern   x values to apply, LSB first
//   length    number of steps; values above PAT_W are clamped to PAT_W
//   hold      defers a pending step while high (no effect during gap cycles)
//   Qa, Qb    present state of the driven FSM
//   E, x      enable and data inputs of the driven FSM
//   busy      sequence in progress (including the done cycle)
//   done      single-cycle completion pulse
//   trace     {Qa,Qb} captured per step; step k lives in [2k+1:2k]
//   state_dbg encoded controller state, for observation only
module fsm_step_sequencer #(
  parameter int PAT_W = 8,
  parameter int GAP   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAT_W-1:0]     pattern,
  input  logic [3:0]           length,
  input  logic                 hold,
  input  logic                 Qa,
  input  logic                 Qb,
  output logic                 E,
  output logic                 x,
  output logic                 busy,
  output logic                 done,
  output logic [2*PAT_W-1:0]   trace,
  output logic [2:0]           state_dbg
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  // The gap counter is loaded with GAP-1, so the GAP state lasts GAP cycles.
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_CAPTURE = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_c;
  logic [3:0]         gap_cnt;
  logic [PAT_W-1:0]   pat_sh;

  // Clamp the requested length to the pattern width.
  always_comb begin
    if (int'(length) > PAT_W) len_c = LEN_MAX;
    else                      len_c = LEN_W'(length);
  end

  // Shift rather than bit-select, so the index width never has to match PAT_W.
  assign pat_sh = pat_q >> cnt;

  // E and x are decoded from registered state. hold gates E in the same
  // cycle, so a deferred step never produces an enable pulse.
  assign E         = (state == S_STEP) && !hold;
  assign x         = (state == S_STEP) && pat_sh[0];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      trace   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pat_q <= pattern;
            len_q <= len_c;
            cnt   <= '0;
            trace <= '0;
            busy  <= 1'b1;
            if (len_c == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
        end

        // The FSM advances on the edge that ends an unheld STEP cycle.
        S_STEP: begin
          if (!hold) state <= S_CAPTURE;
        end

        // {Qa,Qb} now shows the result of the step just applied.
        S_CAPTURE: begin
          for (int k = 0; k < PAT_W; k++) begin
            if (cnt == LEN_W'(k)) trace[2*k +: 2] <= {Qa, Qb};
          end
          if (cnt == len_q - LEN_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + LEN_W'(1);
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              state <= S_STEP;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_STEP;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Bench for fsm_step_sequencer. Two instances share every input: one has
// GAP=0 and the other has GAP=2. Each instance drives its own lab-FSM stub.
// The driver pushes hand-computed expectations when it issues a command.
// Each expectation packs {trace, done latency, E pulse count}. A negedge
// monitor pops an expectation and compares it whenever an instance raises done.
module tb_fsm_step_sequencer;

  localparam int PAT_W = 8;
  localparam int W     = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and stubs ----------------
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [3:0]       length = '0;
  logic             hold = 1'b0;

  logic [1:0]         q0, q2;
  logic               E0, x0, busy0, done0, E2, x2, busy2, done2;
  logic [2*PAT_W-1:0] trace0, trace2;
  logic [2:0]         st0, st2;

  fsm_step_sequencer #(.PAT_W(PAT_W), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .hold(hold), .Qa(q0[1]), .Qb(q0[0]), .E(E0), .x(x0), .busy(busy0),
    .done(done0), .trace(trace0), .state_dbg(st0)
  );

  fsm_step_sequencer #(.PAT_W(PAT_W), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .hold(hold), .Qa(q2[1]), .Qb(q2[0]), .E(E2), .x(x2), .busy(busy2),
    .done(done2), .trace(trace2), .state_dbg(st2)
  );

  // Lab FSM stub: counts up on enabled steps with x=1.
  always @(posedge clk or posedge reset) begin
    if (reset)   q0 <= 2'b00;
    else if (E0) q0 <= q0 + {1'b0, x0};
  end
  always @(posedge clk or posedge reset) begin
    if (reset)   q2 <= 2'b00;
    else if (E2) q2 <= q2 + {1'b0, x2};
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] ent0, ent2;
  int n_vec = 0;
  int n_bad = 0;
  int t0 = 0;
  int e_cnt0 = 0;
  int e_cnt2 = 0;

  function automatic logic [W-1:0] pk(input logic [15:0] tr, input int lat, input int ep);
    return {tr, 8'(lat), 8'(ep)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy0) check("e_with_hold0", {31'd0, E0 && hold}, 32'd0);
      if (E0) e_cnt0++;
      if (done0) begin
        check("done_expected0", {31'd0, exp_q0.size() != 0}, 32'd1);
        if (exp_q0.size() != 0) begin
          ent0 = exp_q0.pop_front();
          check("trace0",    {16'd0, trace0}, {16'd0, ent0[31:16]});
          check("latency0",  cyc - t0 + 1,    {24'd0, ent0[15:8]});
          check("e_pulses0", e_cnt0,          {24'd0, ent0[7:0]});
        end
        e_cnt0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (busy2) check("e_with_hold2", {31'd0, E2 && hold}, 32'd0);
      if (E2) e_cnt2++;
      if (done2) begin
        check("done_expected2", {31'd0, exp_q2.size() != 0}, 32'd1);
        if (exp_q2.size() != 0) begin
          ent2 = exp_q2.pop_front();
          check("trace2",    {16'd0, trace2}, {16'd0, ent2[31:16]});
          check("latency2",  cyc - t0 + 1,    {24'd0, ent2[15:8]});
          check("e_pulses2", e_cnt2,          {24'd0, ent2[7:0]});
        end
        e_cnt2 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_E0",     {31'd0, E0},     32'd0);
    check("rst_busy0",  {31'd0, busy0},  32'd0);
    check("rst_done0",  {31'd0, done0},  32'd0);
    check("rst_trace0", {16'd0, trace0}, 32'd0);
    check("rst_E2",     {31'd0, E2},     32'd0);
    check("rst_busy2",  {31'd0, busy2},  32'd0);
    check("rst_done2",  {31'd0, done2},  32'd0);
    check("rst_trace2", {16'd0, trace2}, 32'd0);
    exp_q0.delete();
    exp_q2.delete();
    e_cnt0 = 0;
    e_cnt2 = 0;
    start = 1'b0;
    hold  = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q2.size() != 0 || busy0 || busy2) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: no done within %0d cycles, pending %0d/%0d", n, exp_q0.size(), exp_q2.size());
      exp_q0.delete();
      exp_q2.delete();
    end
  endtask

  // Returns just after the edge that accepts the command (T0).
  task automatic issue(input logic [PAT_W-1:0] pat, input logic [3:0] len,
                       input logic [W-1:0] exp0, input logic [W-1:0] exp2);
    wait_idle();
    @(posedge clk);
    #1;
    pattern = pat;
    length  = len;
    start   = 1'b1;
    exp_q0.push_back(exp0);
    exp_q2.push_back(exp2);
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1/2: pattern 0B, 4 steps -> trace E9; done at 9 (GAP 0) and 15 (GAP 2)
    issue(8'h0B, 4'd4, pk(16'h00E9, 9, 4), pk(16'h00E9, 15, 4));
    wait_idle();

    // pattern 5A, 3 steps: x=0,1,0 -> 00,01,01 -> trace 14
    do_reset();
    issue(8'h5A, 4'd3, pk(16'h0014, 7, 3), pk(16'h0014, 11, 3));
    wait_idle();

    // 3: hold over cycles 3..5. With GAP 0 the second step slips 3 cycles.
    // With GAP 2, cycles 3..4 are gap cycles, so only the step in cycle 5 slips.
    do_reset();
    issue(8'h0B, 4'd4, pk(16'h00E9, 12, 4), pk(16'h00E9, 16, 4));
    repeat (2) @(posedge clk);
    #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    wait_idle();

    // 4: length 0 -> immediate done; length 12 clamps to 8 steps of x=1
    do_reset();
    issue(8'hAA, 4'd0, pk(16'h0000, 1, 0), pk(16'h0000, 1, 0));
    issue(8'hFF, 4'd12, pk(16'h3939, 17, 8), pk(16'h3939, 31, 8));
    wait_idle();

    // 5: second start while busy carries a different pattern and must be dropped
    do_reset();
    issue(8'h0B, 4'd4, pk(16'h00E9, 9, 4), pk(16'h00E9, 15, 4));
    repeat (2) @(posedge clk);
    #1;
    pattern = 8'hFF;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    // 6: asynchronous reset mid-sequence, then a clean run
    do_reset();
    issue(8'h0B, 4'd4, pk(16'h00E9, 9, 4), pk(16'h00E9, 15, 4));
    repeat (5) @(posedge clk);
    #3;
    do_reset();
    issue(8'h03, 4'd2, pk(16'h0009, 5, 2), pk(16'h0009, 7, 2));
    wait_idle();
    repeat (10) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
